// File: rtl/debounce.sv
`timescale 1ns/1ps
// debounce: two-flop synchroniser followed by a run-length filter that turns a
// bouncing asynchronous input into a clean level plus one-cycle edge pulses.
//
// Ports:
//   clk              system clock, rising edge
//   rst_n            asynchronous active-low reset
//   noisy_signal     raw asynchronous input, may bounce
//   debounced_signal filtered level (registered)
//   rise_pulse       one-cycle high when debounced_signal goes 0->1 (registered)
//   fall_pulse       one-cycle high when debounced_signal goes 1->0 (registered)
module debounce #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter bit          RESET_VALUE   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic noisy_signal,
    output logic debounced_signal,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int unsigned CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync_0;
    logic             sync_1;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] counter_next;
    logic             level_next;

    // Filter decision: any agreement discards the current disagreement run.
    always_comb begin
        counter_next = counter;
        level_next   = debounced_signal;
        if (sync_1 == debounced_signal) begin
            counter_next = '0;
        end else if (counter == CNT_LAST) begin
            level_next   = sync_1;
            counter_next = '0;
        end else begin
            counter_next = counter + CNT_W'(1);
        end
    end

    // Synchroniser, filter state and edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_0           <= RESET_VALUE;
            sync_1           <= RESET_VALUE;
            debounced_signal <= RESET_VALUE;
            counter          <= '0;
            rise_pulse       <= 1'b0;
            fall_pulse       <= 1'b0;
        end else begin
            sync_0           <= noisy_signal;
            sync_1           <= sync_0;
            debounced_signal <= level_next;
            counter          <= counter_next;
            rise_pulse       <= level_next & ~debounced_signal;
            fall_pulse       <= ~level_next & debounced_signal;
        end
    end

endmodule

// File: tb/tb_debounce.sv
`timescale 1ns/1ps
// tb_debounce: scoreboard bench for debounce with STABLE_CYCLES=4, 100 MHz clock.
// Expected {debounced_signal, rise_pulse, fall_pulse} per cycle is queued as the
// stimulus is driven and compared one edge later (sampled 1 ns after posedge).
module tb_debounce;

    logic clk = 1'b0;
    logic rst_n;
    logic noisy_signal;
    logic debounced_signal;
    logic rise_pulse;
    logic fall_pulse;

    logic [2:0] sb[$];
    logic [2:0] got;
    logic [2:0] want;
    int         n_checks = 0;
    int         n_pass   = 0;

    localparam logic [2:0] IDLE0 = 3'b000;
    localparam logic [2:0] HIGH1 = 3'b100;
    localparam logic [2:0] RISE  = 3'b110;
    localparam logic [2:0] FALL  = 3'b001;

    debounce #(.STABLE_CYCLES(4), .RESET_VALUE(1'b0)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .noisy_signal     (noisy_signal),
        .debounced_signal (debounced_signal),
        .rise_pulse       (rise_pulse),
        .fall_pulse       (fall_pulse)
    );

    always #5 clk = ~clk;

    // Drive one input value for one clock and queue the expected post-edge outputs.
    task automatic cycle(input logic v, input logic [2:0] exp);
        @(negedge clk);
        noisy_signal = v;
        sb.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        noisy_signal = 1'b1;
        #1;
        sb.push_back(IDLE0);
        got = {debounced_signal, rise_pulse, fall_pulse}; want = sb.pop_front();
        n_checks++;
        if (got !== want) $display("FAIL reset_t0: got %b want %b", got, want); else n_pass++;
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1, IDLE0);
            got = {debounced_signal, rise_pulse, fall_pulse}; want = sb.pop_front();
            n_checks++;
            if (got !== want) $display("FAIL reset cyc %0d: got %b want %b", i, got, want); else n_pass++;
        end
        @(negedge clk);
        noisy_signal = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_bounce();
        for (int i = 1; i <= 20; i++) begin
            // 10 idle cycles, then 10 cycles alternating 1/0
            cycle((i > 10) ? ((i % 2) == 1) : 1'b0, IDLE0);
            got = {debounced_signal, rise_pulse, fall_pulse}; want = sb.pop_front();
            n_checks++;
            if (got !== want) $display("FAIL bounce cyc %0d: got %b want %b", i, got, want); else n_pass++;
        end
    endtask

    task automatic test_press();
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1, (i < 6) ? IDLE0 : (i == 6) ? RISE : HIGH1);
            got = {debounced_signal, rise_pulse, fall_pulse}; want = sb.pop_front();
            n_checks++;
            if (got !== want) $display("FAIL press cyc %0d: got %b want %b", i, got, want); else n_pass++;
        end
    endtask

    task automatic test_release();
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b0, (i < 6) ? HIGH1 : (i == 6) ? FALL : IDLE0);
            got = {debounced_signal, rise_pulse, fall_pulse}; want = sb.pop_front();
            n_checks++;
            if (got !== want) $display("FAIL release cyc %0d: got %b want %b", i, got, want); else n_pass++;
        end
    endtask

    task automatic test_near_miss();
        logic [11:0] pat;
        pat = 12'b1110_1110_0000; // MSB first: 1,1,1,0,1,1,1,0,...
        for (int i = 0; i < 12; i++) begin
            cycle(pat[11-i], IDLE0);
            got = {debounced_signal, rise_pulse, fall_pulse}; want = sb.pop_front();
            n_checks++;
            if (got !== want) $display("FAIL near_miss cyc %0d: got %b want %b", i, got, want); else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, (i < 6) ? IDLE0 : (i == 6) ? RISE : HIGH1);
            got = {debounced_signal, rise_pulse, fall_pulse}; want = sb.pop_front();
            n_checks++;
            if (got !== want) $display("FAIL async_pre cyc %0d: got %b want %b", i, got, want); else n_pass++;
        end
        // assert reset between edges; outputs must clear without a clock edge
        #2;
        rst_n = 1'b0;
        sb.push_back(IDLE0);
        #1;
        got = {debounced_signal, rise_pulse, fall_pulse}; want = sb.pop_front();
        n_checks++;
        if (got !== want) $display("FAIL async_clear: got %b want %b", got, want); else n_pass++;
        cycle(1'b0, IDLE0);
        got = {debounced_signal, rise_pulse, fall_pulse}; want = sb.pop_front();
        n_checks++;
        if (got !== want) $display("FAIL async_hold: got %b want %b", got, want); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mid_count_reset();
        for (int i = 1; i <= 12; i++) begin
            if (i == 4) begin
                // 1 ns reset pulse straddling edge 4
                sb.push_back(IDLE0);
                #8.5;
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
                #0.5;
            end else begin
                // release takes effect at edge 5; rise is 6 edges later (edge 10)
                cycle(1'b1, (i < 10) ? IDLE0 : (i == 10) ? RISE : HIGH1);
            end
            got = {debounced_signal, rise_pulse, fall_pulse}; want = sb.pop_front();
            n_checks++;
            if (got !== want) $display("FAIL mid_reset cyc %0d: got %b want %b", i, got, want); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_press();
        test_release();
        test_near_miss();
        test_async_reset();
        test_mid_count_reset();
        n_checks++;
        if (sb.size() !== 0) $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100us;
        $display("FAIL timeout: got no finish want finish before 100us");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/debounce.md
Name: debounce

Overview:
- Filters a bouncing, asynchronous single-bit input (button or switch) into a clean, glitch-free level.
- Also produces one-cycle edge pulses for the filtered level.
- Sits between a raw board input pin and synchronous control logic.
- Single clock domain. The input is synchronised internally.

Parameters:
- STABLE_CYCLES, default 4: number of consecutive synchronised samples that must differ from the current output before the output changes. Legal range 1..2^24. Synthesis for a 100 MHz clock overrides this to 1_000_000 (10 ms).
- RESET_VALUE, default 0: level of debounced_signal and of the synchroniser flops after reset.

Ports:
- clk  input  1  system clock, rising-edge, 100 MHz nominal
- rst_n  input  1  asynchronous active-low reset
- noisy_signal  input  1  raw asynchronous input, may bounce
- debounced_signal  output  1  filtered level, registered
- rise_pulse  output  1  one-cycle high when debounced_signal goes 0->1
- fall_pulse  output  1  one-cycle high when debounced_signal goes 1->0

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - sync_0 = sync_1 = RESET_VALUE
  - debounced_signal = RESET_VALUE
  - counter = 0
  - rise_pulse = fall_pulse = 0
- Release of reset takes effect at the next rising edge of clk.
- Synchroniser: two flops, sync_0 <= noisy_signal, then sync_1 <= sync_0. Only sync_1 feeds the filter.
- Counter width is max(1, $clog2(STABLE_CYCLES)). It is unsigned and never wraps.
- Each rising clk edge:
  - If sync_1 == debounced_signal: counter <= 0 (any disagreement run is discarded).
  - Else if counter == STABLE_CYCLES-1: debounced_signal <= sync_1 and counter <= 0.
  - Else: counter <= counter + 1.
- The output therefore changes only after STABLE_CYCLES consecutive edges on which sync_1 disagrees with it.
- Latency from the first clk edge that samples a new, stable noisy_signal level to the output change is 2 + STABLE_CYCLES - 1 further edges. For STABLE_CYCLES=4, the output changes on the 6th rising edge counting the sampling edge as 1.
- A single-cycle agreement in the middle of a run restarts the count from zero.
- Pulses are registered and asserted in the same cycle debounced_signal takes its new value:
  - rise_pulse <= (next output == 1) && (current output == 0)
  - fall_pulse <= (next output == 0) && (current output == 1)
  - Each pulse is exactly one clk cycle wide. rise_pulse and fall_pulse are never high together.
- With STABLE_CYCLES=1 the output follows sync_1 with one cycle of delay. No filtering beyond synchronisation.
- Reset asserted mid-count clears the count. After release, filtering restarts against RESET_VALUE.
- No combinational path from noisy_signal to any output.

Test Plan:
1. Reset: hold rst_n=0 with noisy_signal=1 for 10 cycles -> debounced_signal=0, rise_pulse=0, fall_pulse=0. Assert rst_n asynchronously between clock edges -> outputs clear immediately.
2. Bounce rejection (STABLE_CYCLES=4, 100 MHz): after 100 ns idle, toggle noisy_signal 1/0 every 10 ns for 5 periods -> debounced_signal stays 0, no pulses.
3. Stable press: after step 2, hold noisy_signal=1 for 100 ns -> debounced_signal rises exactly 6 edges after the first sampling edge and stays 1. rise_pulse is high for exactly 1 cycle coincident with the rise.
4. Near-miss: hold noisy_signal=1 for 3 cycles, then 0 for 1 cycle, then 1 for 3 cycles -> no output change and no pulses (count restarted).
5. Release: from debounced_signal=1, drive noisy_signal=0 stable -> output falls after 6 edges. fall_pulse is high for 1 cycle. rise_pulse stays 0.
6. Mid-count reset: drive noisy_signal=1, pulse rst_n low for 1 ns at edge 4, keep input high -> output rises 6 edges after reset release, not earlier.
